// File: rtl/aes_pkg.sv
// Shared AES types: byte and state vectors, SubBytes FSM encoding, and the
// forward S-box contents used by every sbox lane.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} sb_state_e;

  // Forward FIPS-197 substitution table, indexed by the unsigned byte value.
  localparam byte_t SBOX_ROM [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/sbox.sv
// Single forward S-box lane: pure combinational table lookup.
module sbox
  import aes_pkg::*;
(
  input  byte_t din,
  output byte_t dout
);

  assign dout = SBOX_ROM[din];

endmodule

// File: rtl/subbytes_iter.sv
// Iterative forward SubBytes: LANES S-box lanes walk the 128-bit state from
// the MSB slice toward the LSB slice, one slice per cycle, behind a
// valid/ready handshake on each side.
module subbytes_iter
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   in_valid,
  output logic   in_ready,
  input  state_t in_data,
  output logic   out_valid,
  input  logic   out_ready,
  output state_t out_data
);

  localparam int CYCLES  = 16 / LANES;
  localparam int CNT_W   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam int SLICE_W = 8 * LANES;
  // Ones over the top SLICE_W bits; shifted right to address slice cnt.
  localparam state_t TOP_MASK = ~({128{1'b1}} >> SLICE_W);

  sb_state_e        state;
  sb_state_e        state_nx;
  logic [CNT_W-1:0] cnt;
  state_t           work;
  state_t           work_nx;
  state_t           slice_cur;
  state_t           slice_new;
  logic [7:0]       shamt;
  logic             accept;
  logic             last;
  byte_t            lane_in  [LANES];
  byte_t            lane_out [LANES];

  // Slice cnt is brought to the top of a shifted copy so lanes use fixed taps.
  assign shamt     = 8'(cnt) * 8'(SLICE_W);
  assign slice_cur = work << shamt;
  assign accept    = (state == IDLE) && in_valid;
  assign last      = (state == BUSY) && (cnt == CNT_W'(CYCLES - 1));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_in[l] = slice_cur[127 - 8*l -: 8];
    sbox u_sbox (
      .din  (lane_in[l]),
      .dout (lane_out[l])
    );
  end

  // Merge the substituted slice back into its position in the work state.
  always_comb begin
    slice_new = '0;
    for (int l = 0; l < LANES; l++) begin
      slice_new[127 - 8*l -: 8] = lane_out[l];
    end
    work_nx = (work & ~(TOP_MASK >> shamt)) | (slice_new >> shamt);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = BUSY;
      end
      BUSY: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Slice counter, work register and result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      work     <= '0;
      out_data <= '0;
    end else if (accept) begin
      cnt  <= '0;
      work <= in_data;
    end else if (state == BUSY) begin
      work <= work_nx;
      if (last) out_data <= work_nx;
      else      cnt      <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_subbytes_iter.sv
// Bench for subbytes_iter: vector table plus random states against a
// GF(2^8) reference model, backpressure, mid-operation reset, round trip
// and a LANES sweep.
module tb_subbytes_iter;
  import aes_pkg::*;

  logic   clk = 1'b0;
  logic   reset;
  logic   in_valid;
  logic   in_ready;
  state_t in_data;
  logic   out_valid;
  logic   out_ready;
  state_t out_data;
  logic   sw_valid;
  logic   sw_ir [4];
  logic   sw_ov [4];
  state_t sw_od [4];

  int tests = 0;
  int fails = 0;
  byte_t  sbox_m [256];
  byte_t  isbox_m [256];
  state_t last_out;

  always #5 clk = ~clk;

  subbytes_iter #(.LANES(4)) u4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));
  subbytes_iter #(.LANES(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(sw_ir[0]), .in_data(in_data),
    .out_valid(sw_ov[0]), .out_ready(out_ready), .out_data(sw_od[0]));
  subbytes_iter #(.LANES(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(sw_ir[1]), .in_data(in_data),
    .out_valid(sw_ov[1]), .out_ready(out_ready), .out_data(sw_od[1]));
  subbytes_iter #(.LANES(8)) u8 (
    .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(sw_ir[2]), .in_data(in_data),
    .out_valid(sw_ov[2]), .out_ready(out_ready), .out_data(sw_od[2]));
  subbytes_iter #(.LANES(16)) u16 (
    .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(sw_ir[3]), .in_data(in_data),
    .out_valid(sw_ov[3]), .out_ready(out_ready), .out_data(sw_od[3]));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic byte_t gmul(input byte_t a_in, input byte_t b_in);
    byte_t a = a_in;
    byte_t b = b_in;
    byte_t p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic byte_t rotl(input byte_t b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  task automatic build_model();
    for (int x = 0; x < 256; x++) begin
      byte_t inv = 8'h00;
      byte_t s;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox_m[x]  = s;
      isbox_m[s] = 8'(x);
    end
  endtask

  function automatic state_t model_sub(input state_t s);
    state_t r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_m[s[8*i +: 8]];
    return r;
  endfunction

  function automatic state_t model_inv(input state_t s);
    state_t r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = isbox_m[s[8*i +: 8]];
    return r;
  endfunction

  task automatic wait_ready(input string name);
    for (int k = 0; k < 40 && !in_ready; k++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) check({name, " ready timeout"}, 0, 1);
  endtask

  // One transaction on the LANES=4 instance; latency and result checked.
  task automatic xact(input state_t din, input state_t exp, input string name);
    int k;
    wait_ready(name);
    in_valid = 1'b1;
    in_data  = din;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (k = 1; k <= 20; k++) begin
      if (out_valid) break;
      @(posedge clk); #1;
    end
    check({name, " latency"}, 128'(k - 1), 128'd4);
    check({name, " data"}, out_data, exp);
    last_out = out_data;
    if (out_ready) begin
      @(posedge clk); #1;
      check({name, " valid pulse"}, {126'd0, out_valid, in_ready}, 128'b01);
    end
  endtask

  typedef struct {
    state_t din;
    state_t dout;
  } vec_t;

  initial begin
    vec_t   vec [12];
    state_t r;
    state_t hold;
    bit     seen [4];
    int     lanes_of [4] = '{1, 2, 8, 16};

    reset = 1'b1; in_valid = 1'b0; sw_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    build_model();

    vec[0] = '{128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816};
    vec[1] = '{{16{8'h00}}, {16{8'h63}}};
    vec[2] = '{{16{8'h53}}, {16{8'hed}}};
    vec[3] = '{{16{8'hff}}, {16{8'h16}}};
    for (int i = 4; i < 12; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      vec[i] = '{r, model_sub(r)};
    end

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset state", {out_data, 1'b0, in_ready, out_valid}, {128'd0, 3'b010} >> 0);

    for (int i = 0; i < 12; i++) xact(vec[i].din, vec[i].dout, $sformatf("vec%0d", i));

    // Round trip through the inverse table.
    xact(vec[0].din, vec[0].dout, "rt");
    check("round trip", model_inv(last_out), vec[0].din);

    // Backpressure: result held while the consumer stalls.
    r = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b0;
    xact(r, model_sub(r), "bp");
    hold = out_data;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold%0d", c), {out_data, out_valid, in_ready}, {hold, 2'b10});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release", {126'd0, out_valid, in_ready}, 128'b01);
    in_valid = 1'b0;
    check("bp keep data", out_data, hold);

    // Reset while BUSY with cnt=2 discards the work in progress.
    r = {$urandom, $urandom, $urandom, $urandom};
    wait_ready("rst");
    in_valid = 1'b1; in_data = r;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("mid reset", {out_data, out_valid}, 129'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    r = {$urandom, $urandom, $urandom, $urandom};
    xact(r, model_sub(r), "post rst");

    // LANES sweep: same state, latency 16/LANES, identical result.
    in_data = vec[0].din;
    sw_valid = 1'b1;
    @(posedge clk); #1;
    sw_valid = 1'b0;
    seen = '{0, 0, 0, 0};
    for (int k = 1; k <= 20; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (!seen[i] && sw_ov[i]) begin
          seen[i] = 1'b1;
          check($sformatf("sweep L%0d latency", lanes_of[i]), 128'(k - 1), 128'(16 / lanes_of[i]));
          check($sformatf("sweep L%0d data", lanes_of[i]), sw_od[i], vec[0].dout);
        end
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) begin
      if (!seen[i]) check($sformatf("sweep L%0d timeout", lanes_of[i]), 0, 1);
      check($sformatf("sweep L%0d idle", lanes_of[i]), {127'd0, sw_ir[i]}, 128'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
